// File: rtl/i2c_write_engine.sv
// Single-master I2C write engine: START, three bytes with ACK slots, STOP.
// Every bus-level change is registered and lands on a quarter-period boundary.
module i2c_write_engine #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [23:0] data_i,
    output logic        sclk_o,
    inout  wire         sdat_io,
    output logic        done_o,
    output logic        ack_o,
    output logic        busy_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t             state_q, state_n;
    logic [DIV_W-1:0]   div_q, div_n;
    logic [1:0]         qtr_q, qtr_n;
    logic [2:0]         bit_q, bit_n;
    logic [1:0]         byte_q, byte_n;
    logic [23:0]        data_q, data_n;
    logic               ack_ok_q, ack_ok_n;
    logic               sclk_q, sclk_n;
    logic               sda_low_q, sda_low_n;
    logic               done_q, done_n;
    logic               ack_q, ack_n;
    logic               busy_q, busy_n;
    logic [1:0]         sync_q;
    logic               qend;
    logic [4:0]         bit_idx;

    // Open-drain data line: only ever pulled low or released.
    assign sdat_io = sda_low_q ? 1'b0 : 1'bz;

    assign sclk_o = sclk_q;
    assign done_o = done_q;
    assign ack_o  = ack_q;
    assign busy_o = busy_q;

    assign qend = (div_q == DIV_W'(CLK_DIV - 1));

    // Two-flop synchronizer for the returning data line (idles released).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sdat_io};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            data_q    <= '0;
            ack_ok_q  <= 1'b0;
            sclk_q    <= 1'b1;
            sda_low_q <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            div_q     <= div_n;
            qtr_q     <= qtr_n;
            bit_q     <= bit_n;
            byte_q    <= byte_n;
            data_q    <= data_n;
            ack_ok_q  <= ack_ok_n;
            sclk_q    <= sclk_n;
            sda_low_q <= sda_low_n;
            done_q    <= done_n;
            ack_q     <= ack_n;
            busy_q    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        div_n     = '0;
        qtr_n     = qtr_q;
        bit_n     = bit_q;
        byte_n    = byte_q;
        data_n    = data_q;
        ack_ok_n  = ack_ok_q;
        ack_n     = ack_q;
        sclk_n    = 1'b1;
        sda_low_n = 1'b0;
        done_n    = 1'b0;
        busy_n    = 1'b0;
        bit_idx   = '0;

        if (state_q != S_IDLE && state_q != S_DONE) begin
            div_n = qend ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_n  = S_START;
                    data_n   = data_i;
                    qtr_n    = '0;
                    bit_n    = 3'd7;
                    byte_n   = '0;
                    ack_ok_n = 1'b1;
                    ack_n    = 1'b0;
                end
            end
            S_START: begin
                if (qend) begin
                    if (qtr_q == 2'd1) begin
                        state_n = S_BIT;
                        qtr_n   = '0;
                    end else begin
                        qtr_n = qtr_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (qend) begin
                    qtr_n = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            state_n = S_ACK;
                        end else begin
                            bit_n = bit_q - 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                // Acknowledge is judged on the final cycle of the slot.
                if (qend) begin
                    qtr_n = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (sync_q[1]) begin
                            ack_ok_n = 1'b0;
                            state_n  = S_STOP;
                        end else if (byte_q == 2'd2) begin
                            state_n = S_STOP;
                        end else begin
                            byte_n  = byte_q + 2'd1;
                            bit_n   = 3'd7;
                            state_n = S_BIT;
                        end
                    end
                end
            end
            S_STOP: begin
                if (qend) begin
                    if (qtr_q == 2'd2) begin
                        state_n = S_DONE;
                        qtr_n   = '0;
                        ack_n   = ack_ok_q;
                    end else begin
                        qtr_n = qtr_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Bus levels follow the upcoming state so they change exactly on the boundary.
        bit_idx = {2'(2'd2 - byte_n), bit_n};
        case (state_n)
            S_START: begin
                sda_low_n = (qtr_n == 2'd1);
            end
            S_BIT: begin
                sclk_n    = qtr_n[1];
                sda_low_n = ~data_n[bit_idx];
            end
            S_ACK: begin
                sclk_n = qtr_n[1];
            end
            S_STOP: begin
                sclk_n    = (qtr_n != 2'd0);
                sda_low_n = (qtr_n != 2'd2);
            end
            default: begin
                sclk_n    = 1'b1;
                sda_low_n = 1'b0;
            end
        endcase

        done_n = (state_n == S_DONE) && (state_q == S_STOP);
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: quarter-level waveform model, scripted slave, table and random transactions.
module tb_i2c_write_engine;

    localparam int unsigned CLK_DIV = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [23:0] data_i;
    logic        sclk_o;
    wire         sdat_io;
    logic        done_o;
    logic        ack_o;
    logic        busy_o;
    logic        slave_low;

    int n_vec = 0;
    int n_err = 0;

    assign sdat_io = slave_low ? 1'b0 : 1'bz;
    pullup (sdat_io);

    i2c_write_engine #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .data_i  (data_i),
        .sclk_o  (sclk_o),
        .sdat_io (sdat_io),
        .done_o  (done_o),
        .ack_o   (ack_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // One quarter of the expected bus: SCL level, master releases SDA, slave pulls SDA low.
    typedef struct {
        bit scl;
        bit rel;
        bit sl;
    } qtr_t;

    typedef struct {
        logic [23:0] data;
        int          nack_byte;
        int          exp_nq;
        bit          exp_ack;
    } vec_t;

    qtr_t model[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic push4(input bit r, input bit s);
        model.push_back('{scl: 1'b0, rel: r, sl: 1'b0});
        model.push_back('{scl: 1'b0, rel: r, sl: s});
        model.push_back('{scl: 1'b1, rel: r, sl: s});
        model.push_back('{scl: 1'b1, rel: r, sl: s});
    endtask

    // Expected quarter sequence: START, bytes MSB first with ACK slots, early STOP on NACK.
    task automatic build(input logic [23:0] d, input int nack_byte);
        logic [7:0] b;
        bit         acked;
        model.delete();
        model.push_back('{scl: 1'b1, rel: 1'b1, sl: 1'b0});
        model.push_back('{scl: 1'b1, rel: 1'b0, sl: 1'b0});
        for (int by = 0; by < 3; by++) begin
            b = d[23 - 8*by -: 8];
            for (int i = 7; i >= 0; i--) push4(b[i], 1'b0);
            acked = (nack_byte != by + 1);
            push4(1'b1, acked);
            if (!acked) break;
        end
        model.push_back('{scl: 1'b0, rel: 1'b0, sl: 1'b0});
        model.push_back('{scl: 1'b1, rel: 1'b0, sl: 1'b0});
        model.push_back('{scl: 1'b1, rel: 1'b1, sl: 1'b0});
    endtask

    task automatic run_txn(input logic [23:0] d, input int nack_byte, input int exp_nq,
                           input bit exp_ack, input int abort_q, input bit b2b,
                           input logic [23:0] next_d, input int spur_a, input int spur_b);
        int L;
        int q;
        build(d, nack_byte);
        L = exp_nq * CLK_DIV;
        start_i = 1'b1;
        data_i  = d;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        data_i  = 24'($urandom);
        for (int j = 0; j <= L; j++) begin
            q = j / CLK_DIV;
            if (abort_q >= 0 && j == abort_q * CLK_DIV) begin
                slave_low = 1'b0;
                rst_ni    = 1'b0;
                #1;
                check("abort_bus", 8'({sclk_o, sdat_io, busy_o, done_o}), 8'b1100);
                repeat (3) @(posedge clk_i);
                #1;
                rst_ni = 1'b1;
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk_i);
                    #1;
                    check("abort_quiet", 8'({sclk_o, sdat_io, busy_o, done_o}), 8'b1100);
                end
                return;
            end
            start_i = (j == spur_a || j == spur_b);
            if (start_i) data_i = 24'($urandom);
            if (j < L) begin
                if (q < model.size()) begin
                    slave_low = model[q].sl;
                    #1;
                    check("bus", 8'({sclk_o, sdat_io, busy_o, done_o}),
                          8'({model[q].scl, model[q].rel & ~model[q].sl, 1'b1, 1'b0}));
                end else begin
                    #1;
                    check("length", 8'(q), 8'(model.size()));
                end
            end else begin
                slave_low = 1'b0;
                #1;
                check("done", 8'({sclk_o, sdat_io, busy_o, done_o, ack_o}),
                      8'({4'b1111, exp_ack}));
                if (b2b) begin
                    start_i = 1'b1;
                    data_i  = next_d;
                end
            end
            @(posedge clk_i);
            #1;
        end
        check("idle", 8'({sclk_o, sdat_io, busy_o, done_o, ack_o}), 8'({4'b1100, exp_ack}));
    endtask

    initial begin
        vec_t        tbl[4];
        logic [23:0] rd;
        int          nb;

        tbl[0] = '{data: 24'h341E00, nack_byte: 0, exp_nq: 113, exp_ack: 1'b1};
        tbl[1] = '{data: 24'h340C10, nack_byte: 1, exp_nq: 41,  exp_ack: 1'b0};
        tbl[2] = '{data: 24'hA5C37E, nack_byte: 2, exp_nq: 77,  exp_ack: 1'b0};
        tbl[3] = '{data: 24'h5AFF81, nack_byte: 3, exp_nq: 113, exp_ack: 1'b0};

        rst_ni    = 1'b0;
        start_i   = 1'b1;
        data_i    = 24'h341E00;
        slave_low = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset", 8'({sclk_o, sdat_io, busy_o, done_o, ack_o}), 8'b11000);
        rst_ni = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i].data, tbl[i].nack_byte, tbl[i].exp_nq, tbl[i].exp_ack,
                    -1, 1'b0, 24'h0, -1, -1);
        end

        // Starts pulsed mid-transfer must be ignored.
        run_txn(24'h3C55AA, 0, 113, 1'b1, -1, 1'b0, 24'h0, 10, 200);

        // Reset mid-transfer, then a clean transfer.
        run_txn(24'h123456, 0, 113, 1'b1, 50, 1'b0, 24'h0, -1, -1);
        run_txn(24'h123456, 0, 113, 1'b1, -1, 1'b0, 24'h0, -1, -1);

        // Back-to-back: start held from the done cycle, ack_o goes 0 then 1.
        run_txn(24'h341E00, 1, 41, 1'b0, -1, 1'b1, 24'h341201, -1, -1);
        run_txn(24'h341201, 0, 113, 1'b1, -1, 1'b0, 24'h0, -1, -1);

        for (int i = 0; i < 10; i++) begin
            rd = 24'($urandom);
            nb = int'($urandom_range(0, 3));
            run_txn(rd, nb, (nb == 0) ? 113 : 2 + nb * 36 + 3, (nb == 0), -1, 1'b0, 24'h0,
                    (i % 2 == 0) ? int'($urandom_range(1, 100)) : -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_write_engine.md
I2C_WRITE_ENGINE -- requirements
Module: i2c_write_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, system clocks per SCL quarter-period (100 kHz SCL at 50 MHz); legal range 2..65535.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  single-cycle request to begin one write transaction.
REQ-005 SHALL have port data_i  input  24  transaction word: [23:16] device address + R/W bit, [15:8] first data byte, [7:0] second data byte.
REQ-006 SHALL have port sclk_o  output  1  I2C clock, push-pull.
REQ-007 SHALL have port sdat_io  inout  1  I2C data, open-drain: driven 0 or high-Z only, never driven 1.
REQ-008 SHALL have port done_o  output  1  one-cycle pulse when a transaction ends (STOP complete).
REQ-009 SHALL have port ack_o  output  1  1 = all bytes acknowledged; valid from the done_o cycle until the next accepted start.
REQ-010 SHALL have port busy_o  output  1  high from start acceptance through the done_o cycle.

Function
REQ-011 SHALL accept start_i only in IDLE; SHALL latch data_i on the accepting edge; start_i while busy SHALL be ignored with no effect.
REQ-012 SHALL use a divider counting 0..CLK_DIV-1; one quarter (Q) = CLK_DIV cycles; every bus-level change SHALL occur only on a quarter boundary.
REQ-013 SHALL sequence states IDLE -> START -> BIT -> ACK -> (BIT | STOP) -> DONE -> IDLE.
REQ-014 START SHALL last 2Q: Q1 SCL=1/SDA released; Q2 SCL=1/SDA=0.
REQ-015 Each data bit SHALL last 4Q: SCL=0 in Q1-Q2, SCL=1 in Q3-Q4; SDA SHALL change only at the start of Q1.
REQ-016 Bits SHALL be sent MSB first, 8 per byte, bytes in order [23:16], [15:8], [7:0]; bit value 1 = SDA released.
REQ-017 ACK slot SHALL follow each byte: 4Q, same SCL pattern, SDA released.
REQ-018 sdat_io input SHALL pass through a 2-flop synchronizer; ACK SHALL be sampled from the synchronized value on the last cycle of Q4; 0 = ACK, 1 = NACK.
REQ-019 On NACK, SHALL skip remaining bytes, go to STOP, and report ack_o=0.
REQ-020 STOP SHALL last 3Q: Q1 SCL=0/SDA=0; Q2 SCL=1/SDA=0; Q3 SCL=1/SDA released.
REQ-021 Full ACKed transaction SHALL occupy 2+27*4+3 = 113Q; with start accepted at edge k, done_o SHALL be high in the cycle after edge k+113*CLK_DIV, then IDLE.
REQ-022 NACK on byte n (n=1..3) SHALL give done_o 2Q+n*36Q+3Q after acceptance.
REQ-023 Bit counter SHALL run 7..0 and byte counter 0..2; no wrap beyond byte 2.
REQ-024 In IDLE, sclk_o SHALL be 1 and SDA released.
REQ-025 start_i asserted in the done_o cycle SHALL be ignored; it is accepted from the following cycle.

Reset
REQ-026 Reset SHALL force: state IDLE, divider/counters 0, sclk_o=1, SDA released, done_o=0, ack_o=0, busy_o=0, latched data 0.
REQ-027 Reset mid-transaction SHALL release the bus immediately with no STOP, and no done_o SHALL follow.
REQ-028 After reset deassertion, start_i SHALL be accepted on the first rising edge.

Verification (CLK_DIV=4)
REQ-029 Start with data_i=24'h34_1E_00, slave ACKs all -> SDA bit stream 00110100,A,00011110,A,00000000,A framed by START/STOP; done_o at cycle 453 (k=0); ack_o=1.
REQ-030 Slave NACKs address byte of 24'h34_0C_10 -> STOP follows first ACK slot; done_o at 2+36+3=41Q (cycle 165); ack_o=0; bytes 2-3 never driven.
REQ-031 start_i pulsed at cycles 10 and 200 of an active transfer -> exactly one transaction, one done_o pulse.
REQ-032 rst_ni low at Q50 of a transfer -> sclk_o=1, sdat_io=Z same cycle, busy_o=0, no done_o; next start completes normally.
REQ-033 Bus monitor across all tests -> sdat_io never driven 1; SDA changes only while SCL=0 except at START/STOP.
REQ-034 Back-to-back: start_i one cycle after done_o with 24'h34_12_01 -> accepted, second transaction correct, ack_o updated.
